// File: rtl/in_fifo_packer_pkg.sv
// Shared constants and types for the host-byte packer and its command dispatcher.
// The opcode encodings sit here so the dispatcher and the bench see the same values.
package in_fifo_packer_pkg;

    localparam int BP_CMD_W  = 16;
    localparam int BP_BYTE_W = 8;

    localparam logic [1:0] BP_OP_DATA    = 2'd0;
    localparam logic [1:0] BP_OP_CS_LOW  = 2'd1;
    localparam logic [1:0] BP_OP_CS_HIGH = 2'd2;
    localparam logic [1:0] BP_OP_DELAY   = 2'd3;

    typedef enum logic {
        EMPTY_HALF = 1'b0,
        HAVE_HALF  = 1'b1
    } pack_state_e;

    // Places the first byte of a pair in the high or the low half of the command word.
    function automatic logic [BP_CMD_W-1:0] pack_word(input logic [BP_BYTE_W-1:0] first,
                                                      input logic [BP_BYTE_W-1:0] second,
                                                      input logic high_first);
        return high_first ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/in_fifo_packer_if.sv
// Host byte stream, dispatcher pop port and status of the input packer FIFO.
// master = host plus dispatcher side, slave = the packer itself.
interface in_fifo_packer_if #(parameter int DEPTH_LOG2 = 4);
    import in_fifo_packer_pkg::*;

    logic [BP_BYTE_W-1:0] host_data;
    logic                 host_valid;
    logic                 host_ready;
    logic                 flush;
    logic                 in_fifo_out_nempty;
    logic                 in_fifo_out_pop;
    logic [BP_CMD_W-1:0]  in_fifo_out_data;
    logic [DEPTH_LOG2:0]  fifo_level;
    logic                 overflow_err;
    logic                 underflow_err;

    modport master (
        output host_data, host_valid, flush, in_fifo_out_pop,
        input  host_ready, in_fifo_out_nempty, in_fifo_out_data, fifo_level,
               overflow_err, underflow_err
    );

    modport slave (
        input  host_data, host_valid, flush, in_fifo_out_pop,
        output host_ready, in_fifo_out_nempty, in_fifo_out_data, fifo_level,
               overflow_err, underflow_err
    );

endinterface

// File: rtl/in_fifo_packer_sync_fifo.sv
// Synchronous FIFO with a registered read port: popped data appears the cycle after the pop.
// Flush empties the queue but keeps the last popped word on the read port.
module in_fifo_packer_sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_nempty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [DEPTH_LOG2:0]   w_level_next;
    logic [WIDTH-1:0]      r_rd_data;
    logic                  r_nempty;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign w_full  = (r_level == FULL_LEVEL);
    assign w_empty = (r_level == '0);
    assign w_do_wr = i_wr_en && !w_full  && !i_flush;
    assign w_do_rd = i_rd_en && !w_empty && !i_flush;

    always_comb begin
        w_level_next = r_level;
        if (i_flush)
            w_level_next = '0;
        else if (w_do_wr && !w_do_rd)
            w_level_next = r_level + 1'b1;
        else if (!w_do_wr && w_do_rd)
            w_level_next = r_level - 1'b1;
    end

    // Storage carries no reset so it can map onto a plain RAM.
    always_ff @(posedge clock) begin
        if (w_do_wr)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_nempty  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_level  <= w_level_next;
            r_nempty <= (w_level_next != '0);
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_wr)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_rd) begin
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_rd_data <= r_mem[r_rd_ptr];
                end
            end
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_nempty    = r_nempty;
    assign o_full      = w_full;
    assign o_level     = r_level;
    assign o_overflow  = i_wr_en && w_full && !i_flush;
    assign o_underflow = i_rd_en && w_empty && !i_flush;

endmodule

// File: rtl/in_fifo_packer.sv
// Packs pairs of host bytes into 16-bit command words and queues them for the dispatcher.
// host_ready depends only on registered state, so a pop never reaches ready combinationally.
module in_fifo_packer
    import in_fifo_packer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int HIGH_FIRST = 1
) (
    input  logic        clock,
    input  logic        reset,
    in_fifo_packer_if.slave io_bus
);

    pack_state_e          r_state;
    pack_state_e          w_state_next;
    logic [BP_BYTE_W-1:0] r_holder;
    logic                 r_overflow_err;
    logic                 r_underflow_err;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_wr_en;
    logic [BP_CMD_W-1:0]  w_wr_data;
    logic                 w_full;
    logic                 w_ovf_pulse;
    logic                 w_unf_pulse;

    assign w_accept = io_bus.host_valid && w_ready && !io_bus.flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= EMPTY_HALF;
            r_holder <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && r_state == EMPTY_HALF)
                r_holder <= io_bus.host_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (io_bus.flush)
            w_state_next = EMPTY_HALF;
        else if (w_accept)
            w_state_next = (r_state == EMPTY_HALF) ? HAVE_HALF : EMPTY_HALF;
    end

    // A first byte is always taken; only the pairing byte waits for room.
    always_comb begin
        w_ready   = !(r_state == HAVE_HALF && w_full);
        w_wr_en   = w_accept && (r_state == HAVE_HALF);
        w_wr_data = pack_word(r_holder, io_bus.host_data, HIGH_FIRST != 0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_ovf_pulse)
                r_overflow_err <= 1'b1;
            if (w_unf_pulse)
                r_underflow_err <= 1'b1;
        end
    end

    in_fifo_packer_sync_fifo #(
        .WIDTH      (BP_CMD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_flush     (io_bus.flush),
        .i_wr_en     (w_wr_en),
        .i_wr_data   (w_wr_data),
        .i_rd_en     (io_bus.in_fifo_out_pop),
        .o_rd_data   (io_bus.in_fifo_out_data),
        .o_nempty    (io_bus.in_fifo_out_nempty),
        .o_full      (w_full),
        .o_level     (io_bus.fifo_level),
        .o_overflow  (w_ovf_pulse),
        .o_underflow (w_unf_pulse)
    );

    assign io_bus.host_ready    = w_ready;
    assign io_bus.overflow_err  = r_overflow_err;
    assign io_bus.underflow_err = r_underflow_err;

endmodule

// File: tb/tb_in_fifo_packer.sv
// Drives identical traffic into a HIGH_FIRST=1 and a HIGH_FIRST=0 packer and scores both
// against a queue-of-words model; a monitor process checks every popped word.
module tb_in_fifo_packer;
    import in_fifo_packer_pkg::*;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] hostData = 8'h00;
    logic       hostValid = 1'b0;
    logic       popReq = 1'b0;
    logic       flushReq = 1'b0;

    always #5 clock = ~clock;

    in_fifo_packer_if #(.DEPTH_LOG2(DL2)) busHi ();
    in_fifo_packer_if #(.DEPTH_LOG2(DL2)) busLo ();

    assign busHi.host_data = hostData;
    assign busHi.host_valid = hostValid;
    assign busHi.in_fifo_out_pop = popReq;
    assign busHi.flush = flushReq;
    assign busLo.host_data = hostData;
    assign busLo.host_valid = hostValid;
    assign busLo.in_fifo_out_pop = popReq;
    assign busLo.flush = flushReq;

    in_fifo_packer #(.DEPTH_LOG2(DL2), .HIGH_FIRST(1)) dutHi (
        .clock (clock), .reset (reset), .io_bus (busHi));
    in_fifo_packer #(.DEPTH_LOG2(DL2), .HIGH_FIRST(0)) dutLo (
        .clock (clock), .reset (reset), .io_bus (busLo));

    // Model: words held in arrival order as {first byte, second byte}.
    logic [15:0] fifoQ[$];
    logic [15:0] expHi[$];
    logic [15:0] expLo[$];
    bit          haveHalf = 1'b0;
    logic [7:0]  holdByte = 8'h00;
    logic [15:0] lastHi = 16'h0000;
    logic [15:0] lastLo = 16'h0000;
    bit          unfModel = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [15:0] swapBytes(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkState();
        bit expReady;
        expReady = !(haveHalf && fifoQ.size() == DEPTH);
        checkOutput("level_hi", int'(busHi.fifo_level), fifoQ.size());
        checkOutput("level_lo", int'(busLo.fifo_level), fifoQ.size());
        checkOutput("nempty_hi", int'(busHi.in_fifo_out_nempty), int'(fifoQ.size() > 0));
        checkOutput("nempty_lo", int'(busLo.in_fifo_out_nempty), int'(fifoQ.size() > 0));
        checkOutput("ready_hi", int'(busHi.host_ready), int'(expReady));
        checkOutput("ready_lo", int'(busLo.host_ready), int'(expReady));
        checkOutput("overflow_hi", int'(busHi.overflow_err), 0);
        checkOutput("overflow_lo", int'(busLo.overflow_err), 0);
        checkOutput("underflow_hi", int'(busHi.underflow_err), int'(unfModel));
        checkOutput("underflow_lo", int'(busLo.underflow_err), int'(unfModel));
        checkOutput("data_hold_hi", int'(busHi.in_fifo_out_data), int'(lastHi));
        checkOutput("data_hold_lo", int'(busLo.in_fifo_out_data), int'(lastLo));
    endtask

    // One clock of stimulus: update the model for this edge, then check state after it.
    task automatic applyStimulus(input bit rst, input bit valid, input logic [7:0] data,
                                 input bit pop, input bit fl, output bit accepted);
        logic [15:0] w;
        reset = rst;
        hostValid = valid;
        hostData = data;
        popReq = pop;
        flushReq = fl;
        accepted = 1'b0;
        if (rst) begin
            fifoQ.delete();
            haveHalf = 1'b0;
            lastHi = 16'h0000;
            lastLo = 16'h0000;
            unfModel = 1'b0;
        end else if (fl) begin
            fifoQ.delete();
            haveHalf = 1'b0;
        end else begin
            accepted = valid && !(haveHalf && fifoQ.size() == DEPTH);
            if (pop) begin
                if (fifoQ.size() > 0) begin
                    w = fifoQ.pop_front();
                    expHi.push_back(w);
                    expLo.push_back(swapBytes(w));
                    lastHi = w;
                    lastLo = swapBytes(w);
                end else begin
                    unfModel = 1'b1;
                end
            end
            if (accepted) begin
                if (!haveHalf) begin
                    holdByte = data;
                    haveHalf = 1'b1;
                end else begin
                    fifoQ.push_back({holdByte, data});
                    haveHalf = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
        checkState();
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit acc;
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b1, b, 1'b0, 1'b0, acc);
            n++;
        end while (!acc && n < 40);
        if (!acc)
            checkOutput("send_timeout", 0, 1);
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++)
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    endtask

    task automatic popOnce();
        bit acc;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    endtask

    // Scoreboard monitor: any accepted pop must match the oldest expected word.
    always @(posedge clock) begin
        bit fire;
        fire = popReq && busHi.in_fifo_out_nempty && !flushReq && !reset;
        if (fire) begin
            #2;
            if (expHi.size() == 0 || expLo.size() == 0) begin
                checkOutput("unexpected_pop", 1, 0);
            end else begin
                checkOutput("pop_data_hi", int'(busHi.in_fifo_out_data), int'(expHi.pop_front()));
                checkOutput("pop_data_lo", int'(busLo.in_fifo_out_data), int'(expLo.pop_front()));
            end
        end
    end

    initial begin
        bit acc;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        idle(1);

        sendByte(8'h01);
        checkOutput("t1_nempty_after_first", int'(busHi.in_fifo_out_nempty), 0);
        sendByte(8'h20);
        checkOutput("t1_nempty_after_pair", int'(busHi.in_fifo_out_nempty), 1);
        popOnce();
        checkOutput("t1_data_hi", int'(busHi.in_fifo_out_data), 16'h0120);
        checkOutput("t1_level", int'(busHi.fifo_level), 0);

        sendByte(8'hAA);
        sendByte(8'h55);
        popOnce();
        checkOutput("t2_data_lo", int'(busLo.in_fifo_out_data), 16'h55AA);

        for (int i = 0; i < DEPTH; i++) begin
            sendByte(8'h5A);
            sendByte(8'(i));
        end
        sendByte(8'hEE);
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, acc);
        checkOutput("t3_ready_full", int'(busHi.host_ready), 0);
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, acc);
        checkOutput("t3_ready_back", int'(busHi.host_ready), 1);
        sendByte(8'h77);
        checkOutput("t3_level_full", int'(busHi.fifo_level), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            popOnce();
        checkOutput("t3_last_word", int'(busHi.in_fifo_out_data), 16'hEE77);

        popOnce();
        checkOutput("t4_underflow", int'(busHi.underflow_err), 1);
        checkOutput("t4_data_kept", int'(busHi.in_fifo_out_data), 16'hEE77);

        for (int i = 0; i < 3; i++) begin
            sendByte(8'h30);
            sendByte(8'(i));
        end
        for (int i = 0; i < 6; i++) begin
            sendByte(8'h40);
            applyStimulus(1'b0, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0, acc);
            checkOutput("t5_level_steady", int'(busHi.fifo_level), 3);
        end
        for (int i = 0; i < 3; i++)
            popOnce();

        for (int i = 0; i < 5; i++) begin
            sendByte(8'h61);
            sendByte(8'(i));
        end
        sendByte(8'h62);
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, acc);
        checkOutput("t6_flush_level", int'(busHi.fifo_level), 0);
        checkOutput("t6_flush_data", int'(busHi.in_fifo_out_data), 16'h4085);
        sendByte(8'h12);
        sendByte(8'h34);
        popOnce();
        checkOutput("t6_fresh_word", int'(busHi.in_fifo_out_data), 16'h1234);
        sendByte(8'h56);
        applyStimulus(1'b1, 1'b1, 8'h78, 1'b0, 1'b0, acc);
        checkOutput("t6_reset_data", int'(busHi.in_fifo_out_data), 0);
        checkOutput("t6_reset_underflow", int'(busHi.underflow_err), 0);
        sendByte(8'h9A);
        sendByte(8'hBC);
        popOnce();
        checkOutput("t6_after_reset", int'(busHi.in_fifo_out_data), 16'h9ABC);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0, acc);
        end
        while (fifoQ.size() > 0)
            popOnce();
        idle(2);
        checkOutput("scoreboard_drained", expHi.size() + expLo.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
